// File: rtl/eth_phy_10g_pkg.sv
// Shared definitions for the 10GBASE-R RX link controller: state encoding,
// default timeout constants and a width helper.
package eth_phy_10g_pkg;

  // State encodings, kept as localparams so the encoding is visible in one place.
  localparam logic [2:0] STATE_IDLE      = 3'd0;
  localparam logic [2:0] STATE_RESET     = 3'd1;
  localparam logic [2:0] STATE_HOLDOFF   = 3'd2;
  localparam logic [2:0] STATE_WAIT_LOCK = 3'd3;
  localparam logic [2:0] STATE_LINK_UP   = 3'd4;
  localparam logic [2:0] STATE_TEST      = 3'd5;
  localparam logic [2:0] STATE_FAULT     = 3'd6;

  typedef enum logic [2:0] {
    StIdle     = STATE_IDLE,
    StReset    = STATE_RESET,
    StHoldoff  = STATE_HOLDOFF,
    StWaitLock = STATE_WAIT_LOCK,
    StLinkUp   = STATE_LINK_UP,
    StTest     = STATE_TEST,
    StFault    = STATE_FAULT
  } link_state_e;

  // Default timeouts, in rx_clk cycles.
  localparam int unsigned DEF_RESET_CYCLES   = 16;
  localparam int unsigned DEF_HOLDOFF_CYCLES = 64;
  localparam int unsigned DEF_LOCK_TIMEOUT   = 65536;
  localparam int unsigned DEF_BER_TIMEOUT    = 4096;
  localparam int unsigned DEF_MAX_RETRIES    = 15;

  // Counter width able to hold value-1; never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/eth_phy_10g_link_timer.sv
// Loadable up-counter with synchronous clear and terminal-count compare.
module eth_phy_10g_link_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic [WIDTH-1:0] i_tc_val,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  // Count register: clear beats load, load beats increment.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_tc = (r_count == i_tc_val);

endmodule

// File: rtl/eth_phy_10g_rx_link_ctrl.sv
// 10GBASE-R RX link bring-up/recovery controller: sequences SERDES/PCS RX
// resets, waits for lock, supervises lock/BER while up and owns PRBS31 test mode.
module eth_phy_10g_rx_link_ctrl
  import eth_phy_10g_pkg::*;
#(
  parameter int unsigned RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned BER_TIMEOUT    = DEF_BER_TIMEOUT,
  parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic       rx_clk,
  input  logic       rx_rst,
  input  logic       cfg_enable,
  input  logic       cfg_prbs31_req,
  input  logic       rx_block_lock,
  input  logic       rx_high_ber,
  input  logic       rx_status,
  output logic       serdes_rx_reset_req,
  output logic       pcs_rx_rst,
  output logic       link_up,
  output logic       link_fault,
  output logic       cfg_tx_prbs31_enable,
  output logic       cfg_rx_prbs31_enable,
  output logic [3:0] retry_count,
  output logic [7:0] link_drop_count
);

  localparam int unsigned MaxState =
      (RESET_CYCLES > HOLDOFF_CYCLES) ?
      ((RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT) :
      ((HOLDOFF_CYCLES > LOCK_TIMEOUT) ? HOLDOFF_CYCLES : LOCK_TIMEOUT);
  localparam int unsigned TimerW = clog2_min1(MaxState);
  localparam int unsigned BerW   = clog2_min1(BER_TIMEOUT);
  localparam logic [3:0]  RetryMax = 4'(MAX_RETRIES);

  link_state_e       r_state_q;
  link_state_e       w_state_d;
  logic [3:0]        r_retry_q;
  logic [3:0]        w_retry_d;
  logic [3:0]        w_retry_inc;
  logic [7:0]        r_drop_q;
  logic [7:0]        w_drop_d;
  logic [7:0]        w_drop_inc;

  logic              w_timer_en;
  logic              w_timer_clr;
  logic              w_timer_tc;
  logic [TimerW-1:0] w_timer_tc_val;

  logic              w_ber_clr;
  logic              w_ber_tc;
  logic              w_ber_expire;

  logic              r_serdes_rst;
  logic              r_pcs_rst;
  logic              r_link_up;
  logic              r_link_fault;
  logic              r_prbs_en;

  // Terminal count for the shared state timer, selected by the current state.
  always_comb begin
    w_timer_tc_val = '0;
    w_timer_en     = 1'b0;
    unique case (r_state_q)
      StReset: begin
        w_timer_tc_val = TimerW'(RESET_CYCLES - 1);
        w_timer_en     = 1'b1;
      end
      StHoldoff: begin
        w_timer_tc_val = TimerW'(HOLDOFF_CYCLES - 1);
        w_timer_en     = 1'b1;
      end
      StWaitLock: begin
        w_timer_tc_val = TimerW'(LOCK_TIMEOUT - 1);
        w_timer_en     = 1'b1;
      end
      default: ;
    endcase
  end

  // Restart the timer on every state change so each state sees a fresh count.
  assign w_timer_clr = (w_state_d != r_state_q);

  eth_phy_10g_link_timer #(
    .WIDTH (TimerW)
  ) u_state_timer (
    .i_clk      (rx_clk),
    .i_rst      (rx_rst),
    .i_clr      (w_timer_clr),
    .i_en       (w_timer_en),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_tc_val   (w_timer_tc_val),
    .o_tc       (w_timer_tc)
  );

  // BER persistence: counts consecutive high_ber cycles, only while link is up.
  assign w_ber_clr    = (r_state_q != StLinkUp) || !rx_high_ber;
  assign w_ber_expire = (r_state_q == StLinkUp) && rx_high_ber && w_ber_tc;

  eth_phy_10g_link_timer #(
    .WIDTH (BerW)
  ) u_ber_timer (
    .i_clk      (rx_clk),
    .i_rst      (rx_rst),
    .i_clr      (w_ber_clr),
    .i_en       (1'b1),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_tc_val   (BerW'(BER_TIMEOUT - 1)),
    .o_tc       (w_ber_tc)
  );

  assign w_retry_inc = (r_retry_q == RetryMax) ? r_retry_q : r_retry_q + 4'd1;
  assign w_drop_inc  = (r_drop_q == 8'hFF) ? r_drop_q : r_drop_q + 8'd1;

  // Next-state and counter update; cfg_enable low overrides everything.
  always_comb begin
    w_state_d = r_state_q;
    w_retry_d = r_retry_q;
    w_drop_d  = r_drop_q;
    if (!cfg_enable) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state_q)
        StIdle: begin
          w_state_d = StReset;
          w_retry_d = 4'd0;
        end
        StReset: begin
          if (w_timer_tc) w_state_d = StHoldoff;
        end
        StHoldoff: begin
          if (w_timer_tc) w_state_d = StWaitLock;
        end
        StWaitLock: begin
          if (rx_status) begin
            w_state_d = StLinkUp;
            w_retry_d = 4'd0;
          end else if (w_timer_tc) begin
            w_retry_d = w_retry_inc;
            w_state_d = (w_retry_inc == RetryMax) ? StFault : StReset;
          end
        end
        StLinkUp: begin
          if (!rx_block_lock || w_ber_expire) begin
            w_state_d = StReset;
            w_drop_d  = w_drop_inc;
          end else if (cfg_prbs31_req) begin
            w_state_d = StTest;
          end
        end
        StTest: begin
          if (!cfg_prbs31_req) w_state_d = StReset;
        end
        StFault: ;
        default: w_state_d = StIdle;
      endcase
    end
  end

  // State, counters and outputs; outputs decode the next state so they line up
  // with the state register.
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      r_state_q    <= StIdle;
      r_retry_q    <= 4'd0;
      r_drop_q     <= 8'd0;
      r_serdes_rst <= 1'b0;
      r_pcs_rst    <= 1'b0;
      r_link_up    <= 1'b0;
      r_link_fault <= 1'b0;
      r_prbs_en    <= 1'b0;
    end else begin
      r_state_q    <= w_state_d;
      r_retry_q    <= w_retry_d;
      r_drop_q     <= w_drop_d;
      r_serdes_rst <= (w_state_d == StReset);
      r_pcs_rst    <= (w_state_d == StReset);
      r_link_up    <= (w_state_d == StLinkUp);
      r_link_fault <= (w_state_d == StFault);
      r_prbs_en    <= (w_state_d == StTest);
    end
  end

  assign serdes_rx_reset_req  = r_serdes_rst;
  assign pcs_rx_rst           = r_pcs_rst;
  assign link_up              = r_link_up;
  assign link_fault           = r_link_fault;
  assign cfg_tx_prbs31_enable = r_prbs_en;
  assign cfg_rx_prbs31_enable = r_prbs_en;
  assign retry_count          = r_retry_q;
  assign link_drop_count      = r_drop_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_link_ctrl.sv
// Directed self-checking bench for eth_phy_10g_rx_link_ctrl.
module tb_eth_phy_10g_rx_link_ctrl;

  logic       rx_clk;
  logic       rx_rst;
  logic       cfg_enable;
  logic       cfg_prbs31_req;
  logic       rx_block_lock;
  logic       rx_high_ber;
  logic       rx_status;
  logic       serdes_rx_reset_req;
  logic       pcs_rx_rst;
  logic       link_up;
  logic       link_fault;
  logic       cfg_tx_prbs31_enable;
  logic       cfg_rx_prbs31_enable;
  logic [3:0] retry_count;
  logic [7:0] link_drop_count;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;

  eth_phy_10g_rx_link_ctrl #(
    .RESET_CYCLES   (4),
    .HOLDOFF_CYCLES (8),
    .LOCK_TIMEOUT   (32),
    .BER_TIMEOUT    (16),
    .MAX_RETRIES    (3)
  ) dut (
    .rx_clk               (rx_clk),
    .rx_rst               (rx_rst),
    .cfg_enable           (cfg_enable),
    .cfg_prbs31_req       (cfg_prbs31_req),
    .rx_block_lock        (rx_block_lock),
    .rx_high_ber          (rx_high_ber),
    .rx_status            (rx_status),
    .serdes_rx_reset_req  (serdes_rx_reset_req),
    .pcs_rx_rst           (pcs_rx_rst),
    .link_up              (link_up),
    .link_fault           (link_fault),
    .cfg_tx_prbs31_enable (cfg_tx_prbs31_enable),
    .cfg_rx_prbs31_enable (cfg_rx_prbs31_enable),
    .retry_count          (retry_count),
    .link_drop_count      (link_drop_count)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge rx_clk);
    #1;
    cyc++;
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] v;
    v = {serdes_rx_reset_req, pcs_rx_rst, link_up, link_fault,
         cfg_tx_prbs31_enable, cfg_rx_prbs31_enable};
    check_eq(tag, v, 32'd0);
  endtask

  // Count sampled cycles with the reset request high (bounded).
  task automatic count_reset_high(output int n);
    n = 0;
    while (serdes_rx_reset_req && n < 50) begin
      n++;
      step();
    end
  endtask

  task automatic wait_link_up(output int steps);
    steps = 0;
    while (!link_up && steps < 200) begin
      step();
      steps++;
    end
  endtask

  int n;
  int pulses;
  int pulse_cyc [3];
  int pulse_retry [3];
  int fault_cyc;
  logic prev;

  initial begin
    rx_rst         = 1'b1;
    cfg_enable     = 1'b0;
    cfg_prbs31_req = 1'b0;
    rx_block_lock  = 1'b1;
    rx_high_ber    = 1'b0;
    rx_status      = 1'b0;
    #1;
    check_all_zero("reset_outputs");
    check_eq("reset_retry", retry_count, 0);
    check_eq("reset_drop", link_drop_count, 0);
    repeat (3) step();
    rx_rst = 1'b0;
    step();
    check_all_zero("idle_disabled");

    // Normal bring-up.
    cfg_enable = 1'b1;
    step();
    check_eq("bringup_serdes_latency", serdes_rx_reset_req, 1);
    check_eq("bringup_pcs_rst", pcs_rx_rst, 1);
    count_reset_high(n);
    check_eq("bringup_reset_len", n, 4);
    repeat (8) step();
    check_eq("bringup_no_early_link", link_up, 0);
    repeat (4) step();
    rx_status = 1'b1;
    step();
    check_eq("bringup_link_up", link_up, 1);
    check_eq("bringup_retry", retry_count, 0);

    // Lock loss for one cycle.
    rx_block_lock = 1'b0;
    step();
    rx_block_lock = 1'b1;
    check_eq("lockloss_reset", serdes_rx_reset_req, 1);
    check_eq("lockloss_link_down", link_up, 0);
    check_eq("lockloss_drop", link_drop_count, 1);
    wait_link_up(n);
    check_eq("lockloss_relink_cycles", n, 13);

    // High BER: 15 high, 1 low, 15 high stays up.
    rx_high_ber = 1'b1;
    repeat (15) step();
    rx_high_ber = 1'b0;
    step();
    rx_high_ber = 1'b1;
    repeat (15) step();
    rx_high_ber = 1'b0;
    step();
    check_eq("ber_15_stays_up", link_up, 1);
    check_eq("ber_15_no_reset", serdes_rx_reset_req, 0);
    // 16 consecutive high cycles restart the link.
    rx_high_ber = 1'b1;
    repeat (15) step();
    check_eq("ber_15th_still_up", link_up, 1);
    step();
    rx_high_ber = 1'b0;
    check_eq("ber_16_reset", serdes_rx_reset_req, 1);
    check_eq("ber_16_link_down", link_up, 0);
    check_eq("ber_16_drop", link_drop_count, 2);
    wait_link_up(n);
    check_eq("ber_relink_cycles", n, 13);

    // PRBS31 test mode.
    cfg_prbs31_req = 1'b1;
    step();
    check_eq("prbs_tx_en", cfg_tx_prbs31_enable, 1);
    check_eq("prbs_rx_en", cfg_rx_prbs31_enable, 1);
    check_eq("prbs_link_down", link_up, 0);
    rx_block_lock = 1'b0;
    rx_high_ber   = 1'b1;
    step();
    rx_block_lock = 1'b1;
    rx_high_ber   = 1'b0;
    check_eq("prbs_ignores_lock", cfg_tx_prbs31_enable, 1);
    check_eq("prbs_drop_unchanged", link_drop_count, 2);
    cfg_prbs31_req = 1'b0;
    step();
    check_eq("prbs_exit_reset", serdes_rx_reset_req, 1);
    check_eq("prbs_exit_en_off", cfg_rx_prbs31_enable, 0);
    wait_link_up(n);
    check_eq("prbs_resync_cycles", n, 13);

    // Disable: outputs idle, counters retained.
    cfg_enable = 1'b0;
    rx_status  = 1'b0;
    step();
    check_all_zero("disable_idle");
    check_eq("disable_drop_kept", link_drop_count, 2);

    // No lock: three attempts then FAULT.
    pulses    = 0;
    fault_cyc = -1;
    prev      = 1'b0;
    cfg_enable = 1'b1;
    for (int i = 0; i < 400 && fault_cyc < 0; i++) begin
      step();
      if (serdes_rx_reset_req && !prev) begin
        if (pulses < 3) begin
          pulse_cyc[pulses]   = cyc;
          pulse_retry[pulses] = int'(retry_count);
        end
        pulses++;
      end
      prev = serdes_rx_reset_req;
      if (link_fault) fault_cyc = cyc;
    end
    check_eq("nolock_pulses", pulses, 3);
    check_eq("nolock_fault_seen", link_fault, 1);
    if (pulses == 3) begin
      check_eq("nolock_spacing_1", pulse_cyc[1] - pulse_cyc[0], 44);
      check_eq("nolock_spacing_2", pulse_cyc[2] - pulse_cyc[1], 44);
      check_eq("nolock_fault_time", fault_cyc - pulse_cyc[0], 132);
      check_eq("nolock_retry_0", pulse_retry[0], 0);
      check_eq("nolock_retry_1", pulse_retry[1], 1);
      check_eq("nolock_retry_2", pulse_retry[2], 2);
    end
    check_eq("nolock_retry_final", retry_count, 3);
    check_eq("nolock_no_reset_in_fault", serdes_rx_reset_req, 0);
    step();
    check_eq("fault_sticky", link_fault, 1);

    cfg_enable = 1'b0;
    step();
    check_all_zero("fault_exit_idle");
    check_eq("fault_exit_retry_kept", retry_count, 3);
    cfg_enable = 1'b1;
    step();
    check_eq("reenable_reset", serdes_rx_reset_req, 1);
    check_eq("reenable_retry_clear", retry_count, 0);

    // Async reset in the middle of RESET.
    step();
    #2;
    rx_rst = 1'b1;
    #1;
    check_all_zero("async_rst_outputs");
    check_eq("async_rst_drop", link_drop_count, 0);
    #2;
    rx_rst = 1'b0;
    check_all_zero("async_rel_outputs");
    step();
    check_eq("after_rst_latency", serdes_rx_reset_req, 1);
    count_reset_high(n);
    check_eq("after_rst_reset_len", n, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
